router: RTL and testbench
=========================

ROUTER -- requirements
Module: router

Interface
REQ-001 SHALL have ports: clk in 1, clock, all logic on rising edge; reset in 1, synchronous active-low reset.
REQ-002 SHALL have SPI_change in 1: 0 = SPI loader owns all slaves, 1 = RISC-V core owns them.
REQ-003 SHALL have, per master p in {spi, imem, dmem}, AHB-Lite inputs p_haddr 32, p_hwdata 32, p_hprot 4, p_hsize 3, p_hburst 3, p_htrans 2, p_hwrite 1, p_hmastlock 1.
REQ-004 SHALL have, per master, outputs p_hrdata 32, p_hready 1, p_hresp 1 (0 OKAY, 1 ERROR).
REQ-005 SHALL have register slave ports: reg_read in 32; reg_write out 32; reg_addr out 4 (word index); reg_wben out 4; reg_rwn out 1 (1 read, 0 write).
REQ-006 SHALL have instruction RAM ports: inst_read in 32, inst_write out 32, inst_addr out 14, inst_wben out 4, inst_rwn out 1.
REQ-007 SHALL have data RAM ports: data_read, data_write, data_addr, data_wben, data_rwn, same widths as REQ-006.
REQ-008 SHALL ignore hprot, hburst, hmastlock.

Function
REQ-009 Address map on haddr[15:14]: 00 inst RAM (inst_addr = haddr[13:0]), 01 data RAM (data_addr = haddr[13:0]), 10 registers (reg_addr = haddr[5:2]), 11 unmapped; haddr[31:16] ignored.
REQ-010 SPI mode (SPI_change=0): spi may access all three slaves; imem and dmem see hready=0, hresp=0, hrdata=0; their transfers are not accepted.
REQ-011 Core mode (SPI_change=1): imem may access inst RAM only; dmem may access data RAM and registers only; spi sees hready=0; any other region SHALL give ERROR.
REQ-012 Address phase SHALL be accepted when the active master has htrans[1]=1 (NONSEQ/SEQ) and its hready=1; router registers region, address, hsize, hwrite and owning master.
REQ-013 Data phase (cycle after acceptance) SHALL drive the selected slave combinationally: addr from registered address, rwn = ~hwrite, write data = owning master's current hwdata, wben per REQ-014 for writes, 0000 for reads.
REQ-014 wben: hsize 0 -> one-hot bit haddr[1:0]; hsize 1 -> 0011 if haddr[1]=0 else 1100; hsize 2 -> 1111; hsize >2 -> ERROR, no write.
REQ-015 Read data SHALL be returned in the data phase: owner's hrdata = selected slave's read input, same cycle (slaves read combinationally); hready=1, zero wait states.
REQ-016 Non-selected slaves SHALL see rwn=1, wben=0000, addr/write hold last value.
REQ-017 IDLE/BUSY (htrans[1]=0) SHALL produce no slave access and OKAY response.
REQ-018 ERROR SHALL be two-cycle AHB: cycle 1 hresp=1 hready=0, cycle 2 hresp=1 hready=1; no slave access; the next address phase is not accepted during cycle 1.
REQ-019 Back-to-back transfers SHALL pipeline: address of N+1 accepted in the data phase of N.
REQ-020 SPI_change SHALL be sampled each cycle; a pending data phase completes with its original master and slave regardless of SPI_change change; new ownership applies to the next address phase.
REQ-021 hrdata of non-owning or idle masters SHALL be 0.

Reset
REQ-022 On rising clk with reset=0: clear pending data phase and error state; all slave rwn=1, wben=0000, addr=0, write=0.
REQ-023 During/after reset: all hresp=0, hrdata=0; active master hready=1, inactive master hready=0 per REQ-010/011.

Verification
REQ-024 SPI mode, spi write word 0x01234567 to 0x00000000 -> next cycle inst_addr=0, inst_wben=1111, inst_rwn=0, inst_write=0x01234567, spi_hready=1.
REQ-025 Pipelined spi word writes to 0x1, 0x2, 0x4003, 0x4004 -> successive data phases inst_addr 0x1, 0x2, then data_addr 0x0003, 0x0004, one per cycle.
REQ-026 spi byte write hsize=0 to 0x0001 -> inst_wben=0010; halfword to 0x4002 -> data_wben=1100.
REQ-027 spi read 0x8008 with reg_read=0xCAFEF00D -> reg_addr=2, reg_rwn=1, spi_hrdata=0xCAFEF00D in data phase.
REQ-028 spi access 0xC000 -> hresp=1/hready=0 then hresp=1/hready=1, no slave rwn=0; SPI_change=1 then imem read 0x0010 -> inst_addr=0x0010, imem_hrdata=inst_read, spi_hready=0; dmem to 0x0000 -> ERROR.
REQ-029 reset=0 mid-write -> next cycle all rwn=1, wben=0000, no write completes.

Source files
------------

// File: rtl/router_if.sv
// AHB-Lite bus bundle between one master and the router.
interface router_if;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [3:0]  hprot;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        hmastlock;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, hwdata, hprot, hsize, hburst, htrans, hwrite, hmastlock,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwdata, hprot, hsize, hburst, htrans, hwrite, hmastlock,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/router.sv
// Routes three AHB-Lite masters (SPI loader, core imem, core dmem) onto the
// instruction RAM, data RAM and register block. SPI_change selects ownership.
module router (
  input  logic        clk,
  input  logic        reset,
  input  logic        SPI_change,
  router_if.slave     spi,
  router_if.slave     imem,
  router_if.slave     dmem,
  input  logic [31:0] reg_read,
  output logic [31:0] reg_write,
  output logic [3:0]  reg_addr,
  output logic [3:0]  reg_wben,
  output logic        reg_rwn,
  input  logic [31:0] inst_read,
  output logic [31:0] inst_write,
  output logic [13:0] inst_addr,
  output logic [3:0]  inst_wben,
  output logic        inst_rwn,
  input  logic [31:0] data_read,
  output logic [31:0] data_write,
  output logic [13:0] data_addr,
  output logic [3:0]  data_wben,
  output logic        data_rwn
);

  localparam logic [1:0] M_SPI  = 2'd0;
  localparam logic [1:0] M_IMEM = 2'd1;
  localparam logic [1:0] M_DMEM = 2'd2;

  localparam logic [1:0] R_INST = 2'b00;
  localparam logic [1:0] R_DATA = 2'b01;
  localparam logic [1:0] R_REG  = 2'b10;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_DATA,
    PH_ERR1,
    PH_ERR2
  } phase_t;

  // Per-master view of the bus signals
  logic [31:0] m_haddr  [3];
  logic [31:0] m_hwdata [3];
  logic [2:0]  m_hsize  [3];
  logic [1:0]  m_htrans [3];
  logic        m_hwrite [3];
  logic [31:0] hrdata_o [3];
  logic        hready_o [3];
  logic        hresp_o  [3];
  logic        allowed  [3];
  logic        accept   [3];

  // Per-master data-phase state
  phase_t      phase_q  [3];
  phase_t      phase_d  [3];
  logic [1:0]  region_q [3];
  logic [1:0]  region_d [3];
  logic [13:0] addr_q   [3];
  logic [13:0] addr_d   [3];
  logic [2:0]  size_q   [3];
  logic [2:0]  size_d   [3];
  logic        write_q  [3];
  logic        write_d  [3];

  // Slave address/write-data holding registers
  logic [13:0] inst_addr_q, inst_addr_d;
  logic [31:0] inst_write_q, inst_write_d;
  logic [13:0] data_addr_q, data_addr_d;
  logic [31:0] data_write_q, data_write_d;
  logic [3:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_write_q, reg_write_d;

  logic unused_ok;
  assign unused_ok = ^{spi.hprot, spi.hburst, spi.hmastlock, spi.haddr[31:16], spi.htrans[0],
                       imem.hprot, imem.hburst, imem.hmastlock, imem.haddr[31:16], imem.htrans[0],
                       dmem.hprot, dmem.hburst, dmem.hmastlock, dmem.haddr[31:16], dmem.htrans[0]};

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] mask;
    case (size)
      3'd0:    mask = 4'b0001 << a;
      3'd1:    mask = a[1] ? 4'b1100 : 4'b0011;
      3'd2:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic region_ok(input logic [1:0] m, input logic [1:0] r);
    logic ok;
    case (m)
      M_SPI:   ok = (r != 2'b11);
      M_IMEM:  ok = (r == R_INST);
      default: ok = (r == R_DATA) || (r == R_REG);
    endcase
    return ok;
  endfunction

  // Gather master inputs and publish master outputs
  always_comb begin
    m_haddr[0]  = spi.haddr;   m_haddr[1]  = imem.haddr;   m_haddr[2]  = dmem.haddr;
    m_hwdata[0] = spi.hwdata;  m_hwdata[1] = imem.hwdata;  m_hwdata[2] = dmem.hwdata;
    m_hsize[0]  = spi.hsize;   m_hsize[1]  = imem.hsize;   m_hsize[2]  = dmem.hsize;
    m_htrans[0] = spi.htrans;  m_htrans[1] = imem.htrans;  m_htrans[2] = dmem.htrans;
    m_hwrite[0] = spi.hwrite;  m_hwrite[1] = imem.hwrite;  m_hwrite[2] = dmem.hwrite;
  end

  assign spi.hrdata  = hrdata_o[0];
  assign spi.hready  = hready_o[0];
  assign spi.hresp   = hresp_o[0];
  assign imem.hrdata = hrdata_o[1];
  assign imem.hready = hready_o[1];
  assign imem.hresp  = hresp_o[1];
  assign dmem.hrdata = hrdata_o[2];
  assign dmem.hready = hready_o[2];
  assign dmem.hresp  = hresp_o[2];

  // Handshake, address-phase acceptance and next data-phase state per master.
  // A pending data phase keeps hready alive even after ownership moves away.
  always_comb begin
    for (int unsigned m = 0; m < 3; m++) begin
      allowed[m[1:0]] = (m[1:0] == M_SPI) ? ~SPI_change : SPI_change;
      case (phase_q[m[1:0]])
        PH_ERR1:          hready_o[m[1:0]] = 1'b0;
        PH_DATA, PH_ERR2: hready_o[m[1:0]] = 1'b1;
        default:          hready_o[m[1:0]] = allowed[m[1:0]];
      endcase
      hresp_o[m[1:0]] = (phase_q[m[1:0]] == PH_ERR1) || (phase_q[m[1:0]] == PH_ERR2);
      accept[m[1:0]]  = allowed[m[1:0]] && m_htrans[m[1:0]][1] && hready_o[m[1:0]];

      phase_d[m[1:0]]  = PH_IDLE;
      region_d[m[1:0]] = region_q[m[1:0]];
      addr_d[m[1:0]]   = addr_q[m[1:0]];
      size_d[m[1:0]]   = size_q[m[1:0]];
      write_d[m[1:0]]  = write_q[m[1:0]];
      if (phase_q[m[1:0]] == PH_ERR1) begin
        phase_d[m[1:0]] = PH_ERR2;
      end else if (accept[m[1:0]]) begin
        region_d[m[1:0]] = m_haddr[m[1:0]][15:14];
        addr_d[m[1:0]]   = m_haddr[m[1:0]][13:0];
        size_d[m[1:0]]   = m_hsize[m[1:0]];
        write_d[m[1:0]]  = m_hwrite[m[1:0]];
        if (!region_ok(m[1:0], m_haddr[m[1:0]][15:14]) || (m_hsize[m[1:0]] > 3'd2)) begin
          phase_d[m[1:0]] = PH_ERR1;
        end else begin
          phase_d[m[1:0]] = PH_DATA;
        end
      end
    end
  end

  // Drive slaves from whichever master holds a data phase on them
  always_comb begin
    inst_rwn     = 1'b1;
    inst_wben    = '0;
    inst_addr_d  = inst_addr_q;
    inst_write_d = inst_write_q;
    data_rwn     = 1'b1;
    data_wben    = '0;
    data_addr_d  = data_addr_q;
    data_write_d = data_write_q;
    reg_rwn      = 1'b1;
    reg_wben     = '0;
    reg_addr_d   = reg_addr_q;
    reg_write_d  = reg_write_q;
    for (int unsigned m = 0; m < 3; m++) begin
      hrdata_o[m[1:0]] = '0;
    end
    for (int unsigned m = 0; m < 3; m++) begin
      if (phase_q[m[1:0]] == PH_DATA) begin
        case (region_q[m[1:0]])
          R_INST: begin
            inst_addr_d  = addr_q[m[1:0]];
            inst_rwn     = ~write_q[m[1:0]];
            inst_write_d = m_hwdata[m[1:0]];
            inst_wben    = write_q[m[1:0]] ? lane_mask(size_q[m[1:0]], addr_q[m[1:0]][1:0]) : 4'b0000;
            if (!write_q[m[1:0]]) hrdata_o[m[1:0]] = inst_read;
          end
          R_DATA: begin
            data_addr_d  = addr_q[m[1:0]];
            data_rwn     = ~write_q[m[1:0]];
            data_write_d = m_hwdata[m[1:0]];
            data_wben    = write_q[m[1:0]] ? lane_mask(size_q[m[1:0]], addr_q[m[1:0]][1:0]) : 4'b0000;
            if (!write_q[m[1:0]]) hrdata_o[m[1:0]] = data_read;
          end
          R_REG: begin
            reg_addr_d   = addr_q[m[1:0]][5:2];
            reg_rwn      = ~write_q[m[1:0]];
            reg_write_d  = m_hwdata[m[1:0]];
            reg_wben     = write_q[m[1:0]] ? lane_mask(size_q[m[1:0]], addr_q[m[1:0]][1:0]) : 4'b0000;
            if (!write_q[m[1:0]]) hrdata_o[m[1:0]] = reg_read;
          end
          default: ;
        endcase
      end
    end
  end

  assign inst_addr  = inst_addr_d;
  assign inst_write = inst_write_d;
  assign data_addr  = data_addr_d;
  assign data_write = data_write_d;
  assign reg_addr   = reg_addr_d;
  assign reg_write  = reg_write_d;

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned m = 0; m < 3; m++) begin
        phase_q[m[1:0]]  <= PH_IDLE;
        region_q[m[1:0]] <= '0;
        addr_q[m[1:0]]   <= '0;
        size_q[m[1:0]]   <= '0;
        write_q[m[1:0]]  <= 1'b0;
      end
      inst_addr_q  <= '0;
      inst_write_q <= '0;
      data_addr_q  <= '0;
      data_write_q <= '0;
      reg_addr_q   <= '0;
      reg_write_q  <= '0;
    end else begin
      for (int unsigned m = 0; m < 3; m++) begin
        phase_q[m[1:0]]  <= phase_d[m[1:0]];
        region_q[m[1:0]] <= region_d[m[1:0]];
        addr_q[m[1:0]]   <= addr_d[m[1:0]];
        size_q[m[1:0]]   <= size_d[m[1:0]];
        write_q[m[1:0]]  <= write_d[m[1:0]];
      end
      inst_addr_q  <= inst_addr_d;
      inst_write_q <= inst_write_d;
      data_addr_q  <= data_addr_d;
      data_write_q <= data_write_d;
      reg_addr_q   <= reg_addr_d;
      reg_write_q  <= reg_write_d;
    end
  end

endmodule

// File: tb/tb_router.sv
// Directed bench for the router: reset state, SPI loader and core accesses,
// byte lanes, register reads, error responses, ownership switch, reset abort.
module tb_router;
  logic        clk = 1'b0;
  logic        reset;
  logic        SPI_change;
  logic [31:0] reg_read, reg_write;
  logic [3:0]  reg_addr, reg_wben;
  logic        reg_rwn;
  logic [31:0] inst_read, inst_write;
  logic [13:0] inst_addr;
  logic [3:0]  inst_wben;
  logic        inst_rwn;
  logic [31:0] data_read, data_write;
  logic [13:0] data_addr;
  logic [3:0]  data_wben;
  logic        data_rwn;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  router_if spi ();
  router_if imem ();
  router_if dmem ();

  router dut (
    .clk        (clk),
    .reset      (reset),
    .SPI_change (SPI_change),
    .spi        (spi),
    .imem       (imem),
    .dmem       (dmem),
    .reg_read   (reg_read),
    .reg_write  (reg_write),
    .reg_addr   (reg_addr),
    .reg_wben   (reg_wben),
    .reg_rwn    (reg_rwn),
    .inst_read  (inst_read),
    .inst_write (inst_write),
    .inst_addr  (inst_addr),
    .inst_wben  (inst_wben),
    .inst_rwn   (inst_rwn),
    .data_read  (data_read),
    .data_write (data_write),
    .data_addr  (data_addr),
    .data_wben  (data_wben),
    .data_rwn   (data_rwn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // which: 0 spi, 1 imem, 2 dmem
  task automatic drive(input int unsigned which, input logic [31:0] a, input logic [1:0] tr,
                       input logic w, input logic [2:0] sz, input logic [31:0] wd);
    case (which)
      0: begin spi.haddr = a;  spi.htrans = tr;  spi.hwrite = w;  spi.hsize = sz;  spi.hwdata = wd;  end
      1: begin imem.haddr = a; imem.htrans = tr; imem.hwrite = w; imem.hsize = sz; imem.hwdata = wd; end
      default: begin dmem.haddr = a; dmem.htrans = tr; dmem.hwrite = w; dmem.hsize = sz; dmem.hwdata = wd; end
    endcase
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    SPI_change = 1'b0;
    reg_read  = 32'hCAFEF00D;
    inst_read = 32'h13572468;
    data_read = 32'h0BADBEEF;
    spi.hprot = '0;  spi.hburst = '0;  spi.hmastlock = 1'b0;
    imem.hprot = '0; imem.hburst = '0; imem.hmastlock = 1'b0;
    dmem.hprot = '0; dmem.hburst = '0; dmem.hmastlock = 1'b0;
    for (int unsigned i = 0; i < 3; i++) drive(i, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
    tick;
    tick;

    // Reset state
    @(negedge clk);
    check("rst_spi_hready", 32'(spi.hready), 32'd1);
    check("rst_imem_hready", 32'(imem.hready), 32'd0);
    check("rst_spi_hresp", 32'(spi.hresp), 32'd0);
    check("rst_spi_hrdata", spi.hrdata, 32'h0);
    check("rst_rwn", {29'd0, inst_rwn, data_rwn, reg_rwn}, 32'h7);
    check("rst_wben", {20'd0, inst_wben, data_wben, reg_wben}, 32'h0);
    check("rst_inst_addr", 32'(inst_addr), 32'h0);
    reset = 1'b1;
    tick;

    // Single word write to inst RAM
    drive(0, 32'h0000_0000, 2'b10, 1'b1, 3'd2, 32'h0);
    @(negedge clk);
    check("w0_addr_hready", 32'(spi.hready), 32'd1);
    tick;
    drive(0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h01234567);
    @(negedge clk);
    check("w0_inst_addr", 32'(inst_addr), 32'h0);
    check("w0_inst_wben", 32'(inst_wben), 32'hF);
    check("w0_inst_rwn", 32'(inst_rwn), 32'd0);
    check("w0_inst_write", inst_write, 32'h01234567);
    check("w0_spi_hready", 32'(spi.hready), 32'd1);
    check("w0_data_rwn", 32'(data_rwn), 32'd1);
    tick;

    // Pipelined writes crossing from inst RAM to data RAM
    drive(0, 32'h0000_0001, 2'b10, 1'b1, 3'd2, 32'h0);
    tick;
    drive(0, 32'h0000_0002, 2'b11, 1'b1, 3'd2, 32'hA1);
    @(negedge clk);
    check("pipe1_inst_addr", 32'(inst_addr), 32'h1);
    check("pipe1_inst_write", inst_write, 32'hA1);
    tick;
    drive(0, 32'h0000_4003, 2'b10, 1'b1, 3'd2, 32'hA2);
    @(negedge clk);
    check("pipe2_inst_addr", 32'(inst_addr), 32'h2);
    check("pipe2_inst_rwn", 32'(inst_rwn), 32'd0);
    tick;
    drive(0, 32'h0000_4004, 2'b11, 1'b1, 3'd2, 32'hA3);
    @(negedge clk);
    check("pipe3_data_addr", 32'(data_addr), 32'h3);
    check("pipe3_data_rwn", 32'(data_rwn), 32'd0);
    check("pipe3_inst_rwn", 32'(inst_rwn), 32'd1);
    check("pipe3_inst_hold", 32'(inst_addr), 32'h2);
    check("pipe3_data_write", data_write, 32'hA3);
    tick;
    drive(0, 32'h0, 2'b00, 1'b0, 3'd2, 32'hA4);
    @(negedge clk);
    check("pipe4_data_addr", 32'(data_addr), 32'h4);
    tick;
    @(negedge clk);
    check("idle_data_rwn", 32'(data_rwn), 32'd1);
    check("idle_data_wben", 32'(data_wben), 32'h0);
    check("idle_data_hold", 32'(data_addr), 32'h4);
    check("idle_hresp", 32'(spi.hresp), 32'd0);
    tick;

    // Byte and halfword lanes
    drive(0, 32'h0000_0001, 2'b10, 1'b1, 3'd0, 32'h0);
    tick;
    drive(0, 32'h0000_4002, 2'b10, 1'b1, 3'd1, 32'h0000_5500);
    @(negedge clk);
    check("byte_inst_wben", 32'(inst_wben), 32'h2);
    tick;
    drive(0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h1234_0000);
    @(negedge clk);
    check("half_data_wben", 32'(data_wben), 32'hC);
    tick;

    // Register read
    drive(0, 32'h0000_8008, 2'b10, 1'b0, 3'd2, 32'h0);
    tick;
    drive(0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
    @(negedge clk);
    check("rd_reg_addr", 32'(reg_addr), 32'h2);
    check("rd_reg_rwn", 32'(reg_rwn), 32'd1);
    check("rd_reg_wben", 32'(reg_wben), 32'h0);
    check("rd_spi_hrdata", spi.hrdata, 32'hCAFEF00D);
    check("rd_imem_hrdata", imem.hrdata, 32'h0);
    tick;

    // Unmapped region: two-cycle error, next address waits for cycle 2
    drive(0, 32'h0000_C000, 2'b10, 1'b1, 3'd2, 32'h0);
    tick;
    drive(0, 32'h0000_0000, 2'b10, 1'b1, 3'd2, 32'h0);
    @(negedge clk);
    check("err1_hresp", 32'(spi.hresp), 32'd1);
    check("err1_hready", 32'(spi.hready), 32'd0);
    check("err1_rwn", {29'd0, inst_rwn, data_rwn, reg_rwn}, 32'h7);
    tick;
    @(negedge clk);
    check("err2_hresp", 32'(spi.hresp), 32'd1);
    check("err2_hready", 32'(spi.hready), 32'd1);
    check("err2_inst_rwn", 32'(inst_rwn), 32'd1);
    tick;
    drive(0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0000_0077);
    @(negedge clk);
    check("after_err_inst_rwn", 32'(inst_rwn), 32'd0);
    check("after_err_hresp", 32'(spi.hresp), 32'd0);
    check("after_err_write", inst_write, 32'h77);
    tick;

    // Oversized transfer is an error with no write
    drive(0, 32'h0000_0000, 2'b10, 1'b1, 3'd3, 32'h0);
    tick;
    drive(0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
    @(negedge clk);
    check("size3_hresp", 32'(spi.hresp), 32'd1);
    check("size3_inst_rwn", 32'(inst_rwn), 32'd1);
    tick;
    tick;

    // Core mode: imem reads inst RAM, spi is locked out
    SPI_change = 1'b1;
    drive(1, 32'h0000_0010, 2'b10, 1'b0, 3'd2, 32'h0);
    drive(0, 32'h0000_0000, 2'b10, 1'b1, 3'd2, 32'h0);
    @(negedge clk);
    check("core_spi_hready", 32'(spi.hready), 32'd0);
    check("core_imem_hready", 32'(imem.hready), 32'd1);
    tick;
    drive(1, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
    drive(0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
    @(negedge clk);
    check("imem_inst_addr", 32'(inst_addr), 32'h10);
    check("imem_inst_rwn", 32'(inst_rwn), 32'd1);
    check("imem_hrdata", imem.hrdata, 32'h13572468);
    check("core_spi_hrdata", spi.hrdata, 32'h0);
    check("core_spi_hready2", 32'(spi.hready), 32'd0);
    tick;

    // dmem to inst RAM is an error
    drive(2, 32'h0000_0000, 2'b10, 1'b0, 3'd2, 32'h0);
    tick;
    drive(2, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
    @(negedge clk);
    check("dmem_err1", {30'd0, dmem.hresp, dmem.hready}, 32'h2);
    check("dmem_err1_inst_rwn", 32'(inst_rwn), 32'd1);
    tick;
    @(negedge clk);
    check("dmem_err2", {30'd0, dmem.hresp, dmem.hready}, 32'h3);
    tick;

    // dmem register write
    drive(2, 32'h0000_8004, 2'b10, 1'b1, 3'd2, 32'h0);
    tick;
    drive(2, 32'h0, 2'b00, 1'b0, 3'd2, 32'h5A5A_5A5A);
    @(negedge clk);
    check("dmem_reg_addr", 32'(reg_addr), 32'h1);
    check("dmem_reg_rwn", 32'(reg_rwn), 32'd0);
    check("dmem_reg_write", reg_write, 32'h5A5A5A5A);
    tick;

    // Ownership switch with a pending dmem data phase
    drive(2, 32'h0000_4010, 2'b10, 1'b1, 3'd2, 32'h0);
    tick;
    SPI_change = 1'b0;
    drive(2, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0000_0F0F);
    @(negedge clk);
    check("switch_data_addr", 32'(data_addr), 32'h10);
    check("switch_data_rwn", 32'(data_rwn), 32'd0);
    check("switch_dmem_hready", 32'(dmem.hready), 32'd1);
    check("switch_spi_hready", 32'(spi.hready), 32'd1);
    tick;
    @(negedge clk);
    check("switch_dmem_off", 32'(dmem.hready), 32'd0);
    tick;

    // Reset during an address phase aborts the write
    drive(0, 32'h0000_0005, 2'b10, 1'b1, 3'd2, 32'h0);
    reset = 1'b0;
    tick;
    drive(0, 32'h0, 2'b00, 1'b0, 3'd2, 32'hDEAD_DEAD);
    @(negedge clk);
    check("rst_mid_rwn", {29'd0, inst_rwn, data_rwn, reg_rwn}, 32'h7);
    check("rst_mid_wben", {20'd0, inst_wben, data_wben, reg_wben}, 32'h0);
    check("rst_mid_inst_addr", 32'(inst_addr), 32'h0);
    check("rst_mid_hready", 32'(spi.hready), 32'd1);
    reset = 1'b1;
    tick;
    @(negedge clk);
    check("rst_after_inst_rwn", 32'(inst_rwn), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
